// File: rtl/digit_counter_bank.sv
// digit_counter_bank: bank of BCD digits counting synchronized step events in single, carry or max mode.
// Ports:
//   clk      - system clock, all state changes on its rising edge
//   reset    - asynchronous active-high reset
//   step     - asynchronous count request, one count per rising edge
//   dir      - count direction, 1 = up, 0 = down
//   clear    - synchronous clear of the count
//   max_in   - per-digit limit (max mode) or digit-enable bit 4j (carry mode)
//   carry_en - selects carry mode (priority over max_en)
//   max_en   - selects max mode
//   cnt_out  - current BCD count, digit j at [4j+3:4j]
//   wrap     - one-cycle pulse after a wrapping update
module digit_counter_bank #(
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic                dir,
    input  logic                clear,
    input  logic [4*DIGITS-1:0] max_in,
    input  logic                carry_en,
    input  logic                max_en,
    output logic [4*DIGITS-1:0] cnt_out,
    output logic                wrap
);
    typedef enum logic [1:0] {MODE_SINGLE, MODE_MAX, MODE_CARRY} mode_t;
    mode_t mode_q, mode_d;
    logic s1, s2, s3, armed, ev, wrap_d;
    logic [1:0] fill;
    logic [4*DIGITS-1:0] cnt_d, lim, mask, inc, dec, chain_up, chain_dn;
    logic ci, cb, cu, cd, act;
    logic [3:0] dg, ld, d0;
    assign mode_d = carry_en ? MODE_CARRY : max_en ? MODE_MAX : MODE_SINGLE;
    // armed only after a low step level has been seen post-reset, so a step
    // held through reset release cannot masquerade as a rising edge
    assign ev = s2 & ~s3 & armed;
    // per-digit helpers: clamped limit, carry-mode mask, full-chain +/-1
    // and carry-mode chains that skip inactive digits
    always_comb begin
        ci = 1'b1;
        cb = 1'b1;
        cu = 1'b1;
        cd = 1'b1;
        act = 1'b0;
        dg = '0;
        ld = '0;
        lim = '0;
        mask = '0;
        inc = '0;
        dec = '0;
        chain_up = '0;
        chain_dn = '0;
        for (int j = 0; j < DIGITS; j++) begin
            dg = cnt_out[4*j +: 4];
            ld = max_in[4*j +: 4];
            act = (j == 0) || max_in[4*j];
            lim[4*j +: 4] = (ld > 4'd9) ? 4'd9 : ld;
            mask[4*j +: 4] = act ? 4'hF : 4'h0;
            inc[4*j +: 4] = !ci ? dg : (dg == 4'd9) ? 4'd0 : dg + 4'd1;
            dec[4*j +: 4] = !cb ? dg : (dg == 4'd0) ? 4'd9 : dg - 4'd1;
            ci = ci && (dg == 4'd9);
            cb = cb && (dg == 4'd0);
            chain_up[4*j +: 4] = !act ? 4'd0 : !cu ? dg : (dg == 4'd9) ? 4'd0 : dg + 4'd1;
            chain_dn[4*j +: 4] = !act ? 4'd0 : !cd ? dg : (dg == 4'd0) ? 4'd9 : dg - 4'd1;
            cu = act ? (cu && (dg == 4'd9)) : cu;
            cd = act ? (cd && (dg == 4'd0)) : cd;
        end
    end
    always_comb begin
        cnt_d = cnt_out;
        wrap_d = 1'b0;
        d0 = cnt_out[3:0];
        if (clear || (mode_q != mode_d)) begin
            cnt_d = '0;
        end else if (ev) begin
            if (mode_q == MODE_SINGLE) begin
                cnt_d = '0;
                cnt_d[3:0] = dir ? ((d0 == 4'd9) ? 4'd0 : d0 + 4'd1) : ((d0 == 4'd0) ? 4'd9 : d0 - 4'd1);
                wrap_d = dir ? (d0 == 4'd9) : (d0 == 4'd0);
            end else if (mode_q == MODE_CARRY) begin
                cnt_d = dir ? chain_up : chain_dn;
                wrap_d = dir ? cu : cd;
            end else if (lim == '0) begin
                cnt_d = '0;
                wrap_d = 1'b1;
            end else if (dir) begin
                // valid BCD compares correctly as a plain unsigned vector
                cnt_d = (cnt_out >= lim) ? '0 : inc;
                wrap_d = (cnt_out >= lim);
            end else if (cnt_out == '0) begin
                cnt_d = lim;
                wrap_d = 1'b1;
            end else begin
                cnt_d = (cnt_out > lim) ? lim : dec;
            end
        end else if (mode_q == MODE_CARRY) begin
            cnt_d = cnt_out & mask;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            fill <= '0;
            armed <= 1'b0;
            mode_q <= MODE_SINGLE;
            cnt_out <= '0;
            wrap <= 1'b0;
        end else begin
            s1 <= step;
            s2 <= s1;
            s3 <= s2;
            fill <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~s2);
            mode_q <= mode_d;
            cnt_out <= cnt_d;
            wrap <= wrap_d;
        end
    end
endmodule
